alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Front-end sequencer for the mini-project ALU. It captures two 3-bit operands and a carry-in from board switches, one debounced pushbutton press per field. It drives them to the adder's `x`, `y` and `cin` inputs and registers the adder's 4-bit sum `r` into a stable result with a valid flag for the display stage. All operator input arrives through raw buttons, so the block owns synchronisation, debouncing and sequencing.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a button level change is accepted. Legal range is 2..65535; the counter is 16 bits.

**Ports**
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in 3: operand switches, sampled directly at capture (static during capture).
- `cin_sw` in 1: carry-in switch.
- `btn_load` in 1: raw load pushbutton, active-high, asynchronous to `clk`.
- `btn_clear` in 1: raw clear pushbutton, active-high, asynchronous to `clk`.
- `x` out 3: operand A to the adder (registered).
- `y` out 3: operand B to the adder (registered).
- `cin` out 1: carry-in to the adder (registered).
- `sum` in 4: adder result `r`, combinational from `x`/`y`/`cin`.
- `result` out 4: registered copy of `sum`.
- `result_valid` out 1: `result` corresponds to the current `x`/`y`/`cin`.
- `state` out 2: FSM state for the LEDs. `00` is S_X, `01` is S_Y, `10` is S_C, `11` is S_DONE.

## Operation

**Reset**
- While `rst_n` is 0, asynchronously and regardless of `clk`:
  - `x`, `y`, `cin`, `result` and `result_valid` are 0.
  - `state` is S_X.
  - Synchronisers, debounce counters and debounced levels are 0.

**Button path (identical instance per button)**
- Two-flop synchroniser feeds a debouncer.
- The debouncer counter increments while the synchronised level differs from the debounced level. It clears to 0 on any cycle where they are equal.
- When the counter reaches `DEBOUNCE_CYCLES`-1 and the levels still differ, the debounced level toggles and the counter clears.
- A press event is a one-cycle pulse: debounced level 1 while its one-cycle-delayed copy is 0.
- Releases are debounced the same way. A new press event requires the debounced level to return to 0 first.

**FSM on a load event**
- S_X: `x` <= `sw`, go to S_Y.
- S_Y: `y` <= `sw`, go to S_C.
- S_C: `cin` <= `cin_sw`, go to S_DONE.
- S_DONE: starts a new operation.
  - `x` <= `sw`, `result_valid` <= 0, go to S_Y.
  - `y`, `cin` and `result` hold their old values until overwritten.

**Result capture**
- On any edge where state is S_DONE and `result_valid` is 0: `result` <= `sum`, `result_valid` <= 1.
- `result` never changes while `result_valid` is 1.

**Clear event**
- From any state: `x`, `y`, `cin` and `result` go to 0, `result_valid` goes to 0, and state goes to S_X.
- Clear has priority over a simultaneous load event on the same edge.

**Arithmetic**
- No arithmetic in this block. `sum` is taken unmodified as 4 bits.
- The maximum input is 7+7+1 = 15 (`1111`). No overflow handling is required.

## Timing

- Number edges starting with edge 1, the first rising edge at which raw `btn_load` is sampled 1, with the button held high.
  - Debounced level rises at edge `DEBOUNCE_CYCLES`+2.
  - Press pulse is high during the following cycle.
  - FSM capture occurs at edge `DEBOUNCE_CYCLES`+3.
- Glitches or bounces shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no event and no state change.
- Result latency: `result_valid` rises exactly one edge after the edge that enters S_DONE.
  - The adder output settles within that cycle.
  - A load event arriving on that same edge takes priority: it restarts the sequence and `result_valid` stays 0.
- Reset asserted mid-debounce or mid-sequence: everything returns to reset values immediately. On release, the FSM restarts at S_X with no pending events. A button held through reset release generates one press event after the debounce delay.
- Outputs `x`, `y`, `cin`, `result`, `result_valid` and `state` are all registered; none is combinational from inputs.

## Test plan

Bench uses `DEBOUNCE_CYCLES`=4.

- **Reset:** assert `rst_n`=0 asynchronously mid-cycle with prior nonzero state → all outputs 0 and `state`=`00` before the next edge.
- **Full sequence:**
  - Stimulus: clean presses with `sw`=5, then `sw`=6, then `cin_sw`=1; bench adder model returns x+y+cin.
  - `state` steps `00`→`01`→`10`→`11`.
  - `result`=`1100` (12) and `result_valid`=1 one edge after S_DONE is entered.
- **Load latency and bounce:**
  - Raw press with a 2-cycle glitch first → no capture from the glitch.
  - Steady press → capture at edge 7 counted from the steady press's first sampled high.
  - Holding the button produces exactly one event.
- **Overflow boundary:** `x`=7, `y`=7, `cin`=1 → `result`=`1111`, `result_valid`=1.
- **Restart from S_DONE:**
  - Press with `sw`=2 → `x`=2, `result_valid`=0, `state`=`01`.
  - `result` still shows 15 until the next completion.
- **Clear priority:** load and clear debounced events coincide in S_C → `state`=`00`, all data 0, `cin` not captured.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Operator front end for the mini ALU: synchronises and debounces the load/clear buttons,
// sequences x, y and cin captures from the switches, and latches the adder sum with a valid flag.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       cin_sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       cin,
    input  logic [3:0] sum,
    output logic [3:0] result,
    output logic       result_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_X    = 2'b00,
        S_Y    = 2'b01,
        S_C    = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the load button, bit 1 the clear button through every stage.
    logic [1:0]  btn_raw;
    logic [1:0]  sync_p0;
    logic [1:0]  sync_p1;
    logic [1:0]  deb;
    logic [1:0]  deb_d;
    logic [15:0] cnt [2];
    logic [1:0]  press;
    state_t      st;

    assign btn_raw = {btn_clear, btn_load};
    assign press   = deb & ~deb_d;
    assign state   = st;

    // Synchroniser stages, then per-button debounce counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            deb_d   <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            deb_d   <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // Sequencer: clear beats load, load beats the result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_X;
            x            <= '0;
            y            <= '0;
            cin          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (press[1]) begin
            st           <= S_X;
            x            <= '0;
            y            <= '0;
            cin          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (press[0]) begin
            case (st)
                S_X: begin
                    x  <= sw;
                    st <= S_Y;
                end
                S_Y: begin
                    y  <= sw;
                    st <= S_C;
                end
                S_C: begin
                    cin <= cin_sw;
                    st  <= S_DONE;
                end
                default: begin
                    x            <= sw;
                    result_valid <= 1'b0;
                    st           <= S_Y;
                end
            endcase
        end else if (st == S_DONE && !result_valid) begin
            result       <= sum;
            result_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised bench for alu_operand_loader with a window-based behavioural model and directed literal checks.
module tb_alu_operand_loader;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = '0;
    logic       cin_sw = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [2:0] x;
    logic [2:0] y;
    logic       cin;
    logic [3:0] sum;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Adder stand-in: r = x + y + cin.
    assign sum = {1'b0, x} + {1'b0, y} + {3'b000, cin};

    alu_operand_loader #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .cin_sw(cin_sw),
        .btn_load(btn_load),
        .btn_clear(btn_clear),
        .x(x),
        .y(y),
        .cin(cin),
        .sum(sum),
        .result(result),
        .result_valid(result_valid),
        .state(state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: raw-sample history per button; the debounced level flips once the DC
    // synchronised samples seen so far (raw delayed two edges) all disagree with it.
    logic [DC+1:0] hl = '0;
    logic [DC+1:0] hc = '0;
    bit            m_deb_l = 0, m_deb_c = 0, m_dd_l = 0, m_dd_c = 0;
    bit            ev_l, ev_c;
    int            m_stage = 0;
    logic [2:0]    m_x = '0, m_y = '0;
    logic          m_cin = 1'b0;
    logic [3:0]    m_res = '0;
    logic          m_vld = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hl = '0; hc = '0;
            m_deb_l = 0; m_deb_c = 0; m_dd_l = 0; m_dd_c = 0;
            m_stage = 0; m_x = '0; m_y = '0; m_cin = 1'b0; m_res = '0; m_vld = 1'b0;
        end else begin
            ev_l = m_deb_l && !m_dd_l;
            ev_c = m_deb_c && !m_dd_c;
            m_dd_l = m_deb_l;
            m_dd_c = m_deb_c;
            hl = {hl[DC:0], btn_load};
            hc = {hc[DC:0], btn_clear};
            if (hl[DC+1:2] == {DC{~m_deb_l}}) m_deb_l = !m_deb_l;
            if (hc[DC+1:2] == {DC{~m_deb_c}}) m_deb_c = !m_deb_c;
            if (ev_c) begin
                m_stage = 0; m_x = '0; m_y = '0; m_cin = 1'b0; m_res = '0; m_vld = 1'b0;
            end else if (ev_l) begin
                case (m_stage)
                    0: begin m_x = sw; m_stage = 1; end
                    1: begin m_y = sw; m_stage = 2; end
                    2: begin m_cin = cin_sw; m_stage = 3; end
                    default: begin m_x = sw; m_vld = 1'b0; m_stage = 1; end
                endcase
            end else if (m_stage == 3 && !m_vld) begin
                m_res = {1'b0, m_x} + {1'b0, m_y} + {3'b000, m_cin};
                m_vld = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_x", x, m_x);
        chk("cyc_y", y, m_y);
        chk("cyc_cin", cin, m_cin);
        chk("cyc_result", result, m_res);
        chk("cyc_valid", result_valid, m_vld);
        chk("cyc_state", state, m_stage);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [2:0] s, input logic c);
        sw = s;
        cin_sw = c;
        btn_load = 1'b1;
        tick(DC + 6);
        btn_load = 1'b0;
        tick(DC + 6);
    endtask

    initial begin
        tick(2);
        chk("reset_state", state, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_x", x, 0);
        rst_n = 1'b1;
        tick(2);

        // 2-cycle glitch must not capture
        sw = 3'd5;
        btn_load = 1'b1;
        tick(2);
        btn_load = 1'b0;
        tick(10);
        chk("glitch_state", state, 0);
        chk("glitch_x", x, 0);

        // steady press: capture exactly at edge DC+3
        btn_load = 1'b1;
        tick(DC + 2);
        chk("lat_early_state", state, 0);
        tick(1);
        chk("lat_state", state, 1);
        chk("lat_x", x, 5);
        tick(20);
        chk("hold_one_event", state, 1);
        btn_load = 1'b0;
        tick(10);

        press_load(3'd6, 1'b0);
        chk("seq_y", y, 6);
        chk("seq_state_c", state, 2);
        press_load(3'd0, 1'b1);
        chk("seq_cin", cin, 1);
        chk("seq_state_done", state, 3);
        chk("seq_result", result, 12);
        chk("seq_valid", result_valid, 1);

        // new operation toward the 7+7+1 boundary
        press_load(3'd7, 1'b0);
        chk("restart1_x", x, 7);
        chk("restart1_valid", result_valid, 0);
        chk("restart1_result_hold", result, 12);
        press_load(3'd7, 1'b0);
        press_load(3'd0, 1'b1);
        chk("ovf_result", result, 15);
        chk("ovf_valid", result_valid, 1);

        press_load(3'd2, 1'b0);
        chk("restart2_x", x, 2);
        chk("restart2_valid", result_valid, 0);
        chk("restart2_state", state, 1);
        chk("restart2_result", result, 15);

        // simultaneous load and clear while in S_C
        press_load(3'd3, 1'b0);
        chk("pre_clear_state", state, 2);
        cin_sw = 1'b1;
        btn_load = 1'b1;
        btn_clear = 1'b1;
        tick(DC + 6);
        chk("clr_state", state, 0);
        chk("clr_x", x, 0);
        chk("clr_y", y, 0);
        chk("clr_cin", cin, 0);
        chk("clr_result", result, 0);
        chk("clr_valid", result_valid, 0);
        btn_load = 1'b0;
        btn_clear = 1'b0;
        tick(10);

        // randomised presses, bounces and clears against the model
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            sw = 3'($urandom);
            cin_sw = 1'($urandom);
            if (r < 7) btn_load = 1'b1;
            else if (r == 7) btn_clear = 1'b1;
            else if (r == 8) begin btn_load = 1'b1; btn_clear = 1'b1; end
            tick($urandom_range(1, DC + 3));
            btn_load = 1'b0;
            btn_clear = 1'b0;
            tick($urandom_range(1, DC + 4));
        end
        tick(10);

        // asynchronous reset mid-cycle, button held through release
        press_load(3'd5, 1'b0);
        btn_load = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_x", x, 0);
        chk("async_y", y, 0);
        chk("async_cin", cin, 0);
        chk("async_result", result, 0);
        chk("async_valid", result_valid, 0);
        chk("async_state", state, 0);
        tick(3);
        sw = 3'd4;
        rst_n = 1'b1;
        tick(DC + 6);
        chk("held_x", x, 4);
        chk("held_state", state, 1);
        tick(10);
        chk("held_one_event", state, 1);
        btn_load = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
